// File: rtl/ripple_carry_counter_pkg.sv
// Shared definitions for the ripple-carry counter: default width and count type.
package ripple_carry_counter_pkg;

    localparam int DEFAULT_CNT_WIDTH = 4;

    typedef logic [DEFAULT_CNT_WIDTH-1:0] count_t;

endpackage : ripple_carry_counter_pkg

// File: rtl/ripple_carry_counter_tff.sv
// Single toggle flip-flop stage: clears on synchronous active-low reset,
// otherwise flips its state whenever the toggle enable is high.
module ripple_tff (
    input  logic clk,
    input  logic reset,
    input  logic t,
    output logic q
);

    logic r_q;

    // Toggle state register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_q <= 1'b0;
        end else begin
            r_q <= r_q ^ t;
        end
    end

    assign q = r_q;

endmodule : ripple_tff

// File: rtl/ripple_carry_counter.sv
// Free-running binary up-counter built from a chain of toggle stages.
// Stage i toggles when every lower bit is 1; the enable ripples up an AND chain.
module ripple_carry_counter
    import ripple_carry_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_CNT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] w_t;
    logic [WIDTH-1:0] w_q;

    // Carry chain: bit 0 always toggles, bit i toggles when all lower bits are set.
    always_comb begin
        w_t    = '0;
        w_t[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            w_t[i] = w_t[i-1] & w_q[i-1];
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        ripple_tff u_tff (
            .clk   (clk),
            .reset (reset),
            .t     (w_t[i]),
            .q     (w_q[i])
        );
    end

    assign q = w_q;

endmodule : ripple_carry_counter

// File: tb/tb_ripple_carry_counter.sv
`timescale 1ns/1ps
// Bench for ripple_carry_counter: directed scenarios plus randomized reset
// activity checked against an arithmetic reference model, at WIDTH 4 and 8.
module tb_ripple_carry_counter;
    import ripple_carry_counter_pkg::*;

    logic       clk;
    logic       reset;
    count_t     q4;
    logic [7:0] q8;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: count value as plain integers, updated per rising edge.
    int m4 = 0;
    int m8 = 0;

    ripple_carry_counter #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .q     (q4)
    );

    ripple_carry_counter #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .q     (q8)
    );

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    always @(posedge clk) begin
        m4 <= reset ? (m4 + 1) % 16  : 0;
        m8 <= reset ? (m8 + 1) % 256 : 0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(1);
        reset = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev7;
        int toggles;

        reset = 1'b0;

        // Reset held two cycles, then count five edges.
        step(2);
        chk("reset_q4", 32'(q4), 32'd0);
        chk("reset_q8", 32'(q8), 32'd0);
        reset = 1'b1;
        step(5);
        chk("count5_q4", 32'(q4), 32'd5);
        chk("count5_q8", 32'(q8), 32'd5);

        // Full sweep through wrap at WIDTH=4.
        do_reset();
        chk("sweep_start", 32'(q4), 32'd0);
        for (int k = 1; k <= 16; k++) begin
            step(1);
            chk("sweep_q4", 32'(q4), 32'(k % 16));
            chk("sweep_q8", 32'(q8), 32'(k));
        end

        // Reset mid-count at 9, then resume.
        do_reset();
        step(9);
        chk("mid_pre", 32'(q4), 32'd9);
        reset = 1'b0;
        step(1);
        chk("mid_clear", 32'(q4), 32'd0);
        reset = 1'b1;
        step(1);
        chk("mid_resume", 32'(q4), 32'd1);

        // Short reset pulse between edges at q==3 must be ignored.
        do_reset();
        step(3);
        chk("glitch_pre", 32'(q4), 32'd3);
        #20 reset = 1'b0;
        #4  reset = 1'b1;
        step(1);
        chk("glitch_q4", 32'(q4), 32'd4);
        chk("glitch_q8", 32'(q8), 32'd4);

        // Reset at q==15 beats wrap and holds while low.
        do_reset();
        step(15);
        chk("rwrap_pre", 32'(q4), 32'd15);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(1);
            chk("rwrap_hold", 32'(q4), 32'd0);
        end
        reset = 1'b1;

        // WIDTH=8 full sweep; bit 7 toggles only on 127->128 and 255->0.
        do_reset();
        prev7   = 0;
        toggles = 0;
        for (int k = 1; k <= 256; k++) begin
            step(1);
            chk("w8_bit7", 32'(q8[7]), 32'((k % 256) >= 128));
            if (int'(q8[7]) != prev7) begin
                toggles++;
                chk("w8_toggle_at", 32'(k), (toggles == 1) ? 32'd128 : 32'd256);
            end
            prev7 = int'(q8[7]);
            if (k == 255) chk("w8_max", 32'(q8), 32'd255);
        end
        chk("w8_wrap", 32'(q8), 32'd0);
        chk("w8_toggles", 32'(toggles), 32'd2);

        // Randomized reset activity against the reference model.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 15) == 0) begin
                reset = 1'b0;
            end else begin
                reset = 1'b1;
                if ($urandom_range(0, 11) == 0) begin
                    #($urandom_range(5, 30)) reset = 1'b0;
                    #4 reset = 1'b1;
                end
            end
            step(1);
            chk("rand_q4", 32'(q4), 32'(m4));
            chk("rand_q8", 32'(q8), 32'(m8));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_ripple_carry_counter
